// File: rtl/key_word_transform.sv
// AES key-schedule word transform: G = RotWord/SubWord/Rcon, H = SubWord only.
// SBOX_LANES bytes substituted per cycle; result registered, done pulses once.

module sbytes (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign out_byte = SBOX[in_byte];
endmodule

module key_word_transform #(
  parameter int SBOX_LANES = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic        mode,
  input  logic [31:0] word_in,
  input  logic [3:0]  round_num,
  output logic [31:0] word_out,
  output logic        busy,
  output logic        done
);
  if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_bad_lanes
    $error("SBOX_LANES must be 1, 2 or 4");
  end

  // idx wraps to 0 after the final SUB step, so LAST is the idx seen on that step
  localparam logic [1:0] STEP = 2'(SBOX_LANES);
  localparam logic [1:0] LAST = 2'(4 - SBOX_LANES);

  typedef enum logic [1:0] {IDLE, SUB, FINISH} state_t;

  state_t            state_q, state_d;
  logic [0:3][7:0]   work_q, work_d;
  logic [1:0]        idx_q, idx_d;
  logic              mode_q, mode_d;
  logic [3:0]        round_q, round_d;
  logic [31:0]       word_out_q, word_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        lane_out [SBOX_LANES];

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  for (genvar l = 0; l < SBOX_LANES; l++) begin : g_lane
    logic [1:0] bsel;
    assign bsel = idx_q + 2'(l);
    sbytes u_sbytes (.in_byte(work_q[bsel]), .out_byte(lane_out[l]));
  end

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    idx_d      = idx_q;
    mode_d     = mode_q;
    round_d    = round_q;
    word_out_d = word_out_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          round_d = round_num;
          work_d  = mode ? word_in : {word_in[23:0], word_in[31:24]};
          idx_d   = 2'd0;
          busy_d  = 1'b1;
          state_d = SUB;
        end
      end
      SUB: begin
        for (int l = 0; l < SBOX_LANES; l++) begin
          work_d[idx_q + 2'(l)] = lane_out[l];
        end
        idx_d = idx_q + STEP;
        if (idx_q == LAST) state_d = FINISH;
      end
      FINISH: begin
        word_out_d = mode_q ? work_q : (work_q ^ {rcon(round_q), 24'h0});
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      work_q     <= '0;
      idx_q      <= 2'd0;
      mode_q     <= 1'b0;
      round_q    <= 4'd0;
      word_out_q <= 32'h0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      round_q    <= round_d;
      word_out_q <= word_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign word_out = word_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_key_word_transform.sv
// Directed bench for key_word_transform with 1-, 2- and 4-lane instances
// sharing reset and data inputs, each with its own start.

module tb_key_word_transform;
  logic        clk;
  logic        n_rst;
  logic [2:0]  start_v;
  logic        mode;
  logic [31:0] word_in;
  logic [3:0]  round_num;
  logic [31:0] wo [3];
  logic [2:0]  busy_v;
  logic [2:0]  done_v;

  int n_cmp = 0;
  int n_err = 0;

  key_word_transform #(.SBOX_LANES(1)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .start(start_v[0]), .mode(mode), .word_in(word_in),
    .round_num(round_num), .word_out(wo[0]), .busy(busy_v[0]), .done(done_v[0]));
  key_word_transform #(.SBOX_LANES(2)) u_dut2 (
    .clk(clk), .n_rst(n_rst), .start(start_v[1]), .mode(mode), .word_in(word_in),
    .round_num(round_num), .word_out(wo[1]), .busy(busy_v[1]), .done(done_v[1]));
  key_word_transform #(.SBOX_LANES(4)) u_dut4 (
    .clk(clk), .n_rst(n_rst), .start(start_v[2]), .mode(mode), .word_in(word_in),
    .round_num(round_num), .word_out(wo[2]), .busy(busy_v[2]), .done(done_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start one transform on instance d; returns edges-to-done, busy cycles and result.
  task automatic do_xform(input int d, input logic m, input logic [31:0] w,
                          input logic [3:0] r, output int lat, output int busy_cnt,
                          output logic [31:0] res);
    mode      = m;
    word_in   = w;
    round_num = r;
    start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
    lat      = -1;
    busy_cnt = 0;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      if (done_v[d]) lat = i;
      else begin
        if (busy_v[d]) busy_cnt++;
        tick();
      end
    end
    res = wo[d];
  endtask

  initial begin
    int lat, bc, ndone;
    logic [31:0] res;

    n_rst = 1'b0; start_v = 3'b000; mode = 1'b0; word_in = 32'h0; round_num = 4'd0;
    tick(); tick();
    chk("rst_word_out", wo[0], 32'h0);
    chk("rst_busy", {29'h0, busy_v}, 32'h0);
    chk("rst_done", {29'h0, done_v}, 32'h0);
    n_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_busy_done", {26'h0, busy_v, done_v}, 32'h0);
    end
    chk("idle_word_out", wo[0] | wo[1] | wo[2], 32'h0);

    // FIPS-197 G vector, one lane
    do_xform(0, 1'b0, 32'h09CF4F3C, 4'd1, lat, bc, res);
    chk("g1_result", res, 32'h8B84EB01);
    chk("g1_latency", 32'(lat), 32'd5);
    chk("g1_busy_cycles", 32'(bc), 32'd5);

    // H mode on 4 and 2 lanes
    do_xform(2, 1'b1, 32'h09CF4F3C, 4'd0, lat, bc, res);
    chk("h4_result", res, 32'h018A84EB);
    chk("h4_latency", 32'(lat), 32'd2);
    do_xform(1, 1'b1, 32'h09CF4F3C, 4'd0, lat, bc, res);
    chk("h2_result", res, 32'h018A84EB);
    chk("h2_latency", 32'(lat), 32'd3);

    // Rcon boundaries
    do_xform(0, 1'b0, 32'h0, 4'd10, lat, bc, res);
    chk("rcon10", res, 32'h55636363);
    do_xform(0, 1'b0, 32'h0, 4'd0, lat, bc, res);
    chk("rcon0", res, 32'h63636363);
    do_xform(0, 1'b0, 32'h0, 4'd11, lat, bc, res);
    chk("rcon11", res, 32'h63636363);
    do_xform(1, 1'b0, 32'h0, 4'd9, lat, bc, res);
    chk("rcon9_lanes2", res, 32'h78636363);
    do_xform(2, 1'b0, 32'h0, 4'd8, lat, bc, res);
    chk("rcon8_lanes4", res, 32'he3636363);
    tick();

    // Start while busy is ignored; inputs changed mid-transform have no effect
    mode = 1'b0; word_in = 32'h09CF4F3C; round_num = 4'd1;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    lat = -1; ndone = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 2) begin
        start_v[0] = 1'b1; mode = 1'b1; word_in = 32'hFFFFFFFF; round_num = 4'd5;
      end
      if (i == 3) start_v[0] = 1'b0;
      if (done_v[0]) begin
        ndone++;
        if (lat < 0) begin
          lat = i;
          res = wo[0];
        end
      end
      tick();
    end
    chk("ign_done_count", 32'(ndone), 32'd1);
    chk("ign_latency", 32'(lat), 32'd5);
    chk("ign_result", res, 32'h8B84EB01);

    // Back-to-back: second start lands on the done edge
    do_xform(0, 1'b0, 32'h09CF4F3C, 4'd1, lat, bc, res);
    chk("b2b_first", res, 32'h8B84EB01);
    do_xform(0, 1'b1, 32'h0, 4'd0, lat, bc, res);
    chk("b2b_second", res, 32'h63636363);
    chk("b2b_latency", 32'(lat), 32'd5);
    tick();
    chk("done_single_cycle", {31'h0, done_v[0]}, 32'h0);
    chk("word_out_hold", wo[0], 32'h63636363);

    // Reset on the third SUB edge aborts the transform
    mode = 1'b0; word_in = 32'h09CF4F3C; round_num = 4'd1;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    tick(); tick();
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    chk("abort_busy", {31'h0, busy_v[0]}, 32'h0);
    chk("abort_done", {31'h0, done_v[0]}, 32'h0);
    chk("abort_word_out", wo[0], 32'h0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done_v[0] || busy_v[0]) ndone++;
    end
    chk("abort_no_activity", 32'(ndone), 32'd0);
    do_xform(0, 1'b0, 32'h09CF4F3C, 4'd1, lat, bc, res);
    chk("after_abort_result", res, 32'h8B84EB01);
    chk("after_abort_latency", 32'(lat), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
